// File: rtl/tpm_cmd_header_parser.sv
`timescale 1ns/1ps
// Byte-serial TPM command header parser: extracts tag/size/code/first param and validates header.
// Latency: cmd_valid the cycle after the final byte; byte_ready low while a command is presented.
module tpm_cmd_header_parser #(
  parameter int unsigned MAX_CMD_SIZE = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        abort,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [15:0] cmd_tag,
  output logic [31:0] cmd_size,
  output logic [31:0] tpm_cc,
  output logic [15:0] cc_param,
  output logic [31:0] hdr_rc
);

  localparam logic [31:0] MAX_SIZE        = 32'(MAX_CMD_SIZE);
  localparam logic [31:0] RC_OK           = 32'h0000_0000;
  localparam logic [31:0] RC_BAD_TAG      = 32'h0000_001E;
  localparam logic [31:0] RC_COMMAND_SIZE = 32'h0000_0142;

  typedef enum logic [2:0] {
    S_TAG,
    S_SIZE,
    S_CODE,
    S_PARAM,
    S_DRAIN,
    S_PRESENT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic        accept;
  logic        last_byte;
  logic        tag_ok;
  logic        size_bad;
  logic [31:0] chk_rc;

  assign byte_ready = (state != S_PRESENT);
  assign cmd_valid  = (state == S_PRESENT);
  assign accept     = byte_valid & byte_ready;
  assign last_byte  = ((cnt + 32'd1) == cmd_size);

  // Tag and size are fully captured by the time byte 9 arrives; tag errors win over size errors.
  assign tag_ok   = (cmd_tag == 16'h8001) || (cmd_tag == 16'h8002);
  assign size_bad = (cmd_size < 32'd10) || (cmd_size > MAX_SIZE);
  assign chk_rc   = !tag_ok ? RC_BAD_TAG : (size_bad ? RC_COMMAND_SIZE : RC_OK);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_TAG;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_TAG;
    end else begin
      case (state)
        S_TAG:     if (accept && cnt == 32'd1) state_nxt = S_SIZE;
        S_SIZE:    if (accept && cnt == 32'd5) state_nxt = S_CODE;
        S_CODE: begin
          if (accept && cnt == 32'd9) begin
            if (chk_rc != RC_OK || cmd_size == 32'd10) state_nxt = S_PRESENT;
            else                                       state_nxt = S_PARAM;
          end
        end
        S_PARAM: begin
          if (accept) begin
            if (last_byte)            state_nxt = S_PRESENT;
            else if (cnt == 32'd11)   state_nxt = S_DRAIN;
          end
        end
        S_DRAIN:   if (accept && last_byte) state_nxt = S_PRESENT;
        S_PRESENT: if (cmd_ready) state_nxt = S_TAG;
        default:   state_nxt = S_TAG;
      endcase
    end
  end

  // Fields shift in MSB first; the first byte of a command wipes the previous command's results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      cmd_tag  <= '0;
      cmd_size <= '0;
      tpm_cc   <= '0;
      cc_param <= '0;
      hdr_rc   <= '0;
    end else if (abort) begin
      cnt      <= '0;
      cmd_tag  <= '0;
      cmd_size <= '0;
      tpm_cc   <= '0;
      cc_param <= '0;
      hdr_rc   <= '0;
    end else if (cmd_valid && cmd_ready) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 32'd1;
      if (cnt == 32'd0) begin
        cmd_tag  <= {8'h00, byte_in};
        cmd_size <= '0;
        tpm_cc   <= '0;
        cc_param <= '0;
        hdr_rc   <= '0;
      end else if (cnt == 32'd1) begin
        cmd_tag <= {cmd_tag[7:0], byte_in};
      end else if (cnt <= 32'd5) begin
        cmd_size <= {cmd_size[23:0], byte_in};
      end else if (cnt <= 32'd9) begin
        tpm_cc <= {tpm_cc[23:0], byte_in};
        if (cnt == 32'd9) hdr_rc <= chk_rc;
      end else if (cnt <= 32'd11 && cmd_size >= 32'd12) begin
        cc_param <= {cc_param[7:0], byte_in};
      end
    end
  end

endmodule

// File: tb/tb_tpm_cmd_header_parser.sv
`timescale 1ns/1ps
// Directed bench for tpm_cmd_header_parser; inputs change 1ns after the rising edge, outputs sampled there too.
module tb_tpm_cmd_header_parser;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        abort = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [15:0] cmd_tag;
  logic [31:0] cmd_size;
  logic [31:0] tpm_cc;
  logic [15:0] cc_param;
  logic [31:0] hdr_rc;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] pkt[$];

  tpm_cmd_header_parser #(.MAX_CMD_SIZE(4096)) dut (
    .clock      (clock),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .abort      (abort),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_tag    (cmd_tag),
    .cmd_size   (cmd_size),
    .tpm_cc     (tpm_cc),
    .cc_param   (cc_param),
    .hdr_rc     (hdr_rc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    chk("byte_ready_before_send", {31'd0, byte_ready}, 32'd1);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic send_pkt(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(pkt[i]);
  endtask

  task automatic handshake();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("valid_after_handshake", {31'd0, cmd_valid}, 32'd0);
    chk("ready_after_handshake", {31'd0, byte_ready}, 32'd1);
  endtask

  task automatic check_startup(input string nm);
    chk({nm, "_valid"}, {31'd0, cmd_valid}, 32'd1);
    chk({nm, "_tag"}, {16'd0, cmd_tag}, 32'h8001);
    chk({nm, "_size"}, cmd_size, 32'd12);
    chk({nm, "_cc"}, tpm_cc, 32'h144);
    chk({nm, "_param"}, {16'd0, cc_param}, 32'h0);
    chk({nm, "_rc"}, hdr_rc, 32'h0);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_ready", {31'd0, byte_ready}, 32'd1);
    chk("rst_tag", {16'd0, cmd_tag}, 32'd0);
    chk("rst_size", cmd_size, 32'd0);
    chk("rst_cc", tpm_cc, 32'd0);
    chk("rst_param", {16'd0, cc_param}, 32'd0);
    chk("rst_rc", hdr_rc, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: Startup(CLEAR)
    pkt = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};
    send_pkt(0, 10);
    chk("t1_valid_before_last", {31'd0, cmd_valid}, 32'd0);
    send_pkt(11, 11);
    check_startup("t1");
    handshake();

    // 2: Shutdown(STATE) with consumer stalling 5 cycles while bytes are offered
    pkt = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h45, 8'h00, 8'h01};
    send_pkt(0, 11);
    byte_in    = 8'hFF;
    byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_ready", {31'd0, byte_ready}, 32'd0);
      chk("t2_stall_valid", {31'd0, cmd_valid}, 32'd1);
      chk("t2_stall_cc", tpm_cc, 32'h145);
      chk("t2_stall_param", {16'd0, cc_param}, 32'h0001);
      chk("t2_stall_size", cmd_size, 32'd12);
      tick();
    end
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    handshake();
    chk("t2_param_held_after", {16'd0, cc_param}, 32'h0001);

    // 3: bad tag 80 03 presents right after byte 10
    pkt = '{8'h80, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44};
    send_pkt(0, 9);
    chk("t3_valid", {31'd0, cmd_valid}, 32'd1);
    chk("t3_rc", hdr_rc, 32'h01E);
    chk("t3_ready", {31'd0, byte_ready}, 32'd0);
    chk("t3_tag", {16'd0, cmd_tag}, 32'h8003);
    handshake();

    // 4a: size 9
    pkt = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h01, 8'h44};
    send_pkt(0, 9);
    chk("t4a_valid", {31'd0, cmd_valid}, 32'd1);
    chk("t4a_rc", hdr_rc, 32'h142);
    handshake();

    // 4b: size MAX_CMD_SIZE+1
    pkt = '{8'h80, 8'h02, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 8'h00, 8'h01, 8'h45};
    send_pkt(0, 9);
    chk("t4b_valid", {31'd0, cmd_valid}, 32'd1);
    chk("t4b_rc", hdr_rc, 32'h142);
    chk("t4b_size", cmd_size, 32'd4097);
    handshake();

    // 4c: bad tag and bad size together -> tag error wins
    pkt = '{8'h00, 8'hC1, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h01, 8'h44};
    send_pkt(0, 9);
    chk("t4c_rc", hdr_rc, 32'h01E);
    handshake();

    // size 10: no parameter bytes, presents immediately
    pkt = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h7A};
    send_pkt(0, 9);
    chk("s10_valid", {31'd0, cmd_valid}, 32'd1);
    chk("s10_rc", hdr_rc, 32'h0);
    chk("s10_param", {16'd0, cc_param}, 32'h0);
    handshake();

    // size 11: single param byte is taken and discarded
    pkt = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h01, 8'h44, 8'h5A};
    send_pkt(0, 9);
    chk("s11_valid_mid", {31'd0, cmd_valid}, 32'd0);
    send_pkt(10, 10);
    chk("s11_valid", {31'd0, cmd_valid}, 32'd1);
    chk("s11_param", {16'd0, cc_param}, 32'h0);
    handshake();

    // 5: size 20, params AB CD plus 8 filler bytes drained
    pkt = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h01, 8'h7B, 8'hAB, 8'hCD,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt(0, 18);
    chk("t5_valid_before_last", {31'd0, cmd_valid}, 32'd0);
    send_pkt(19, 19);
    chk("t5_valid", {31'd0, cmd_valid}, 32'd1);
    chk("t5_param", {16'd0, cc_param}, 32'hABCD);
    chk("t5_cc", tpm_cc, 32'h17B);
    chk("t5_size", cmd_size, 32'd20);
    chk("t5_rc", hdr_rc, 32'h0);
    handshake();

    // 6: abort after byte 4 (with a byte offered in the abort cycle)
    pkt = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};
    send_pkt(0, 3);
    abort      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h99;
    tick();
    abort      = 1'b0;
    byte_valid = 1'b0;
    chk("t6_abort_valid", {31'd0, cmd_valid}, 32'd0);
    chk("t6_abort_tag", {16'd0, cmd_tag}, 32'd0);
    chk("t6_abort_size", cmd_size, 32'd0);

    // async reset after byte 7 of a new command
    send_pkt(0, 6);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_tag", {16'd0, cmd_tag}, 32'd0);
    chk("t6_rst_valid", {31'd0, cmd_valid}, 32'd0);
    #1;
    reset = 1'b0;
    tick();
    chk("t6_rst_size", cmd_size, 32'd0);

    send_pkt(0, 10);
    chk("t6_valid_before_last", {31'd0, cmd_valid}, 32'd0);
    send_pkt(11, 11);
    check_startup("t6");
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
